dm_arbiter: RTL
===============

# dm_arbiter

Shared data-memory responder for the multi-core array. It serves the memory side of each processor core's data port: the core drives address, write data and write enable, and this block returns read data. The block owns the shared data-memory array and serialises concurrent writes, one commit per cycle. It also drives each core's `status` input, including a hold state while that core's write is queued, and collects `end_process` into a single job-done handshake toward the top level.

## Interface
- `N_CORES`, 2: number of processor cores served (2..8)
- `DATA_W`, 16: data word width
- `DEPTH`, 256: memory words (power of two); index = low log2(DEPTH) address bits
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: one-cycle pulse, launches all cores
- `core_addr` in N_CORES*16: per-core data address (core i at [16i+15:16i])
- `core_wdata` in N_CORES*DATA_W: per-core write data
- `core_we` in N_CORES: per-core data-memory write enable
- `core_end` in N_CORES: per-core end_process
- `core_rdata` out N_CORES*DATA_W: per-core read data (to core DM_out)
- `core_status` out N_CORES*2: per-core status; 00 idle, 01 run, 10 hold
- `busy` out 1: high in RUN or DRAIN
- `done` out 1: one-cycle pulse at job completion

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on `start`.
  - RUN -> DRAIN when every core's sticky end flag is set.
  - DRAIN -> IDLE when no write is pending; `done` pulses on that transition.
  - `start` outside IDLE is ignored.
- Sticky end flags: `end_seen[i]` sets on `core_end[i]` in RUN and clears on entry to RUN.
- Status: 01 in RUN, or in DRAIN before the core's end flag is set. 10 while core i's pending buffer is full. 00 in IDLE and once `end_seen[i]` is set with no pending write.
- Write candidates per cycle:
  - the core's pending buffer, if full;
  - otherwise a new `core_we[i]` from a core in RUN status.
  - `core_we` from a core in hold or idle status is ignored.
- Exactly one candidate commits per cycle, chosen by the arbiter.
  - A new request that loses is captured into that core's 1-deep pending buffer (addr, data).
  - The core shows hold from the next cycle until its buffer commits.
- Reads: `core_rdata[i]` registers mem[core_addr[i]] every cycle, in any state.
  - Same-cycle write to the same index returns the old data (read-before-write).
- Address bits above log2(DEPTH) are ignored, so addresses alias modulo DEPTH.
- Reset: all outputs 0, FSM IDLE, pending buffers and end flags cleared, arbiter pointer 0. Memory contents are not reset.
  - Reset mid-run discards pending writes. A write committing on the reset edge does not occur.

## Timing
- Read latency: 1 cycle, address at edge k -> data valid after edge k+1.
- Uncontested write: commits at the same edge as `core_we`; readable the next cycle.
- A contested write waits at most N_CORES-1 cycles in round-robin mode.
- `busy` rises the cycle after `start`.
- `done` is high for exactly one cycle, the cycle after the last pending write commits, or the cycle after the last end flag sets if nothing is pending.

## Configuration
- Macro: `DM_ARB_ROUND_ROBIN_EN`.
- Defined: rotating priority. The pointer advances to (winner+1) mod N_CORES after each commit.
- Undefined: fixed priority, lowest core index wins. The pointer is removed.
- Both modes: at most one commit per cycle, and pending buffers still capture losers.

## Structure
- Package `dm_arb_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN);
  - status encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_HOLD=2'b10.
- Sub-module `dm_arb_pick`: combinational one-hot winner select from the candidate vector and pointer, per the macro.
- Top: FSM, pending buffers, memory array, read registers.

## Test plan
- Reset, then `start`, then core0 writes 0x1234 to address 5; core1 reads address 5 two cycles later -> `core_rdata[1]`=0x1234. No hold on either core.
- Both cores write the same cycle (core0: addr 3 = 0xAAAA, core1: addr 4 = 0xBBBB) -> core0 commits, core1 status=10 for one cycle, both values readable after 2 cycles.
- Round-robin: both cores write on three consecutive cycles -> winners alternate 0, 1, 0. With the macro undefined, core0 wins every new contest.
- Core0 asserts `core_end` while core1 writes; core1 then asserts `core_end` while its buffer is pending -> DRAIN for 1 cycle, then `done` pulses once and `busy`=0.
- `rst` asserted while core1's buffer holds 0x5555 -> buffer discarded, address unchanged, all outputs 0 the following cycle.
- Address 0x0105 with DEPTH=256 -> aliases index 5. Read and write of index 5 in the same cycle return the old value.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg
// Shared types and constants for the shared data-memory arbiter.
//   state_t   : controller states IDLE / RUN / DRAIN
//   ST_*      : per-core status encodings driven back to the cores
//   ADDR_W    : width of each core's data address
//   statusOf  : maps hold/active flags onto a status encoding
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    localparam int ADDR_W = 16;

    // Hold wins over run: a core with a queued write must stall even if it
    // would otherwise still be running.
    function automatic logic [1:0] statusOf(input logic hold, input logic active);
        if (hold) begin
            return ST_HOLD;
        end
        return active ? ST_RUN : ST_IDLE;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if
// Bundle of every core's data-memory port, packed core-major.
//   core_addr   : per-core data address, core i at [16i+15:16i]
//   core_wdata  : per-core write data
//   core_we     : per-core write enable
//   core_end    : per-core end_process
//   core_rdata  : per-core registered read data
//   core_status : per-core status (idle / run / hold)
// Modports: master = core side, slave = arbiter side.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int N_CORES = 2,
    parameter int DATA_W  = 16
);

    logic [N_CORES*ADDR_W-1:0] core_addr;
    logic [N_CORES*DATA_W-1:0] core_wdata;
    logic [N_CORES-1:0]        core_we;
    logic [N_CORES-1:0]        core_end;
    logic [N_CORES*DATA_W-1:0] core_rdata;
    logic [N_CORES*2-1:0]      core_status;

    modport master (
        output core_addr, core_wdata, core_we, core_end,
        input  core_rdata, core_status
    );

    modport slave (
        input  core_addr, core_wdata, core_we, core_end,
        output core_rdata, core_status
    );

endinterface

// File: rtl/dm_arb_pick.sv
// dm_arb_pick
// Combinational one-hot winner select over the write-candidate vector.
//   req_i   : one bit per core that has a write to commit this cycle
//   ptr_i   : first core in priority order (round-robin build only)
//   grant_o : one-hot winner, all zero when nothing is requested
// Macro DM_ARB_ROUND_ROBIN_EN selects rotating priority starting at ptr_i;
// without it the lowest core index always wins and there is no pointer.
module dm_arb_pick #(
    parameter int N = 2
) (
`ifdef DM_ARB_ROUND_ROBIN_EN
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
`endif
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);

`ifdef DM_ARB_ROUND_ROBIN_EN
    int dist;
    int bestDist;

    // Winner is the requester with the smallest rotated distance from ptr_i.
    always_comb begin
        grant_o  = '0;
        dist     = 0;
        bestDist = N;
        for (int j = 0; j < N; j++) begin
            dist = (j + N - int'(ptr_i)) % N;
            if (req_i[j] && (dist < bestDist)) begin
                bestDist   = dist;
                grant_o    = '0;
                grant_o[j] = 1'b1;
            end
        end
    end
`else
    // Scanning downwards lets the lowest requesting index overwrite the rest.
    always_comb begin
        grant_o = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter
// Shared data-memory responder for the multi-core array. Owns the memory
// array, commits at most one core write per cycle, queues losing writes in a
// 1-deep per-core buffer (holding that core), and folds every core's
// end_process into a single job-done pulse.
//   clk, rst : clock and synchronous active-high reset
//   start    : one-cycle launch pulse, honoured only in IDLE
//   busy     : high while the job is in RUN or DRAIN
//   done     : one-cycle pulse when the job completes
//   bus      : dm_arbiter_if slave port carrying all per-core signals
// Macro DM_ARB_ROUND_ROBIN_EN enables rotating arbitration priority;
// the default build uses fixed lowest-index priority.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int N_CORES = 2,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    dm_arbiter_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_t                    state_q, state_d;
    logic [N_CORES-1:0]        end_seen_q, end_seen_d;
    logic [N_CORES-1:0]        pend_q, pend_d;
    logic [AW-1:0]             pend_addr_q [N_CORES];
    logic [AW-1:0]             pend_addr_d [N_CORES];
    logic [DATA_W-1:0]         pend_data_q [N_CORES];
    logic [DATA_W-1:0]         pend_data_d [N_CORES];
    logic [N_CORES*2-1:0]      status_q, status_d;
    logic [N_CORES*DATA_W-1:0] rdata_q;
    logic                      busy_q, done_q, done_d;

    logic [N_CORES-1:0]        cand;
    logic [N_CORES-1:0]        grant;
    logic                      wr_en;
    logic [AW-1:0]             wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [DATA_W-1:0]         mem [DEPTH];

    // Address bits above the index only alias; fold them away explicitly.
    logic addr_unused;
    assign addr_unused = ^bus.core_addr;

    // A queued write always competes; a fresh write only counts from a core
    // whose registered status is RUN, so held or idle cores are ignored.
    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            cand[i] = pend_q[i] | (bus.core_we[i] & (status_q[2*i +: 2] == ST_RUN));
        end
    end

`ifdef DM_ARB_ROUND_ROBIN_EN
    localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (grant[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    dm_arb_pick #(.N(N_CORES)) u_pick (
        .ptr_i   (ptr_q),
        .req_i   (cand),
        .grant_o (grant)
    );
`else
    dm_arb_pick #(.N(N_CORES)) u_pick (
        .req_i   (cand),
        .grant_o (grant)
    );
`endif

    // The winner's write comes from its buffer when one is queued, otherwise
    // straight from the bus. Fresh losers are captured into their buffer.
    always_comb begin
        wr_en       = |grant;
        wr_addr     = '0;
        wr_data     = '0;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        for (int i = 0; i < N_CORES; i++) begin
            if (grant[i]) begin
                if (pend_q[i]) begin
                    wr_addr   = pend_addr_q[i];
                    wr_data   = pend_data_q[i];
                    pend_d[i] = 1'b0;
                end else begin
                    wr_addr = bus.core_addr[ADDR_W*i +: AW];
                    wr_data = bus.core_wdata[DATA_W*i +: DATA_W];
                end
            end else if (cand[i] && !pend_q[i]) begin
                pend_d[i]      = 1'b1;
                pend_addr_d[i] = bus.core_addr[ADDR_W*i +: AW];
                pend_data_d[i] = bus.core_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    // Job controller. The RUN exit looks at the flags including this cycle's
    // end_process so the last core's end moves straight into DRAIN; DRAIN
    // then waits until every queued write has been committed.
    always_comb begin
        state_d    = state_q;
        end_seen_d = end_seen_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    end_seen_d = '0;
                end
            end
            RUN: begin
                end_seen_d = end_seen_q | bus.core_end;
                if (&end_seen_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pend_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        status_d = '0;
        for (int i = 0; i < N_CORES; i++) begin
            status_d[2*i +: 2] = statusOf(pend_d[i], (state_d != IDLE) && !end_seen_d[i]);
        end
    end

    // All control state and the registered outputs update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            end_seen_q <= '0;
            pend_q     <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DM_ARB_ROUND_ROBIN_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            end_seen_q  <= end_seen_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            status_q    <= status_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= done_d;
            for (int i = 0; i < N_CORES; i++) begin
                rdata_q[DATA_W*i +: DATA_W] <= mem[bus.core_addr[ADDR_W*i +: AW]];
            end
`ifdef DM_ARB_ROUND_ROBIN_EN
            if (wr_en) begin
                ptr_q <= (win_idx == PW'(N_CORES - 1)) ? '0 : win_idx + 1'b1;
            end
`endif
        end
    end

    // Memory is never cleared; a commit coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign bus.core_rdata  = rdata_q;
    assign bus.core_status = status_q;

endmodule
